// File: rtl/not_stim_gen_if.sv
// not_stim_gen_if
//   Bundles the control and pattern signals of the inverter stimulus driver.
//   master : the sequencer side (bench or on-chip controller)
//   slave  : the not_stim_gen side
//   Signals:
//     start        master->slave  request a run (honoured only when idle)
//     abort        master->slave  terminate a run (honoured only while running)
//     init_level   master->slave  a_out level for the first half-period
//     half_period  master->slave  cycles per level, 0 treated as 1
//     num_toggles  master->slave  a_out inversions per run, 0 legal
//     a_out        slave->master  registered pattern to the inverter input
//     busy         slave->master  high while a run is in progress
//     done         slave->master  one-cycle pulse on normal completion
//     toggle_cnt   slave->master  inversions performed in current/last run
//
// Handshake: start is a request that is accepted on the first rising edge
// where start=1 and the driver is idle; acceptance is visible as busy=1 on
// the following cycle. While busy=1 further start pulses are dropped (no
// queueing). A run ends either with busy falling together with a single
// done=1 cycle (normal completion) or with busy falling and done staying 0
// (abort). Run parameters are captured at acceptance, so the master may
// change them freely once busy is seen.
interface not_stim_gen_if #(
    parameter int HP_W  = 8,
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             abort;
    logic             init_level;
    logic [HP_W-1:0]  half_period;
    logic [CNT_W-1:0] num_toggles;
    logic             a_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output start, abort, init_level, half_period, num_toggles,
        input  a_out, busy, done, toggle_cnt
    );

    modport slave (
        input  start, abort, init_level, half_period, num_toggles,
        output a_out, busy, done, toggle_cnt
    );
endinterface

// File: rtl/not_stim_gen.sv
// not_stim_gen
//   Upstream stimulus driver for the pmos/nmos inverter cell. Produces a
//   square pattern on a_out with programmable start level, half-period and
//   number of inversions, sequenced by a start/busy/done handshake.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bus        if   not_stim_gen_if.slave (start/abort/params in, pattern/status out)
//   state_dbg  out  current FSM state (IDLE=0, RUN=1, DONE=2) for observation
// All outputs come straight from registers; nothing combinational reaches
// the interface outputs from its inputs.
module not_stim_gen #(
    parameter int HP_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    not_stim_gen_if.slave        bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             a_q, a_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [HP_W-1:0]  timer_q, timer_nxt;
    logic [HP_W-1:0]  hp_q, hp_nxt;     // latched effective half-period, always >= 1
    logic [CNT_W-1:0] nt_q, nt_nxt;     // latched toggle target

    // A programmed half-period of 0 behaves as 1.
    logic [HP_W-1:0]  hp_eff;
    assign hp_eff = (bus.half_period == '0) ? HP_W'(1) : bus.half_period;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            timer_q <= '0;
            hp_q    <= HP_W'(1);
            nt_q    <= '0;
        end else begin
            state   <= state_nxt;
            a_q     <= a_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            cnt_q   <= cnt_nxt;
            timer_q <= timer_nxt;
            hp_q    <= hp_nxt;
            nt_q    <= nt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        cnt_nxt   = cnt_q;
        timer_nxt = timer_q;
        hp_nxt    = hp_q;
        nt_nxt    = nt_q;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_RUN;
                    a_nxt     = bus.init_level;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    timer_nxt = hp_eff - HP_W'(1);
                    hp_nxt    = hp_eff;
                    nt_nxt    = bus.num_toggles;
                end
            end

            S_RUN: begin
                // abort wins over a coinciding timer expiry or toggle
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                end else if (timer_q != '0) begin
                    timer_nxt = timer_q - HP_W'(1);
                end else if (cnt_q != nt_q) begin
                    a_nxt     = ~a_q;
                    cnt_nxt   = cnt_q + CNT_W'(1);
                    timer_nxt = hp_q - HP_W'(1);
                end else begin
                    // last level has been held a full half-period
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end

            S_DONE: begin
                // done is high for exactly this one cycle; start is not looked at
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.a_out      = a_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.toggle_cnt = cnt_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_not_stim_gen.sv
// tb_not_stim_gen
//   Bench for not_stim_gen. The reference model describes a run as a list of
//   per-cycle observations {a_out, busy, done, toggle_cnt} derived directly
//   from the pattern rules: level k (k = 0..N) lasts max(hp,1) cycles with
//   value init ^ (k odd), then one done cycle, then idle hold.
module tb_not_stim_gen;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    not_stim_gen_if #(.HP_W(8), .CNT_W(8)) bus ();

    not_stim_gen #(.HP_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [10:0] exp_q[$];
    int          total;
    int          bad;

    function automatic logic [10:0] observed();
        return {bus.a_out, bus.busy, bus.done, bus.toggle_cnt};
    endfunction

    // Expected per-cycle observations starting with the cycle right after
    // the start edge. abort_c >= 0 means abort is presented at the edge that
    // ends run cycle abort_c. idle_n cycles of idle hold are appended.
    function automatic void build_run(input logic init, input int hp, input int n,
                                      input int abort_c, input int idle_n);
        int         hpe;
        int         run_c;
        logic       a;
        logic [7:0] cnt;
        hpe   = (hp == 0) ? 1 : hp;
        run_c = (n + 1) * hpe;
        exp_q.delete();
        for (int c = 0; c < run_c; c++) begin
            a   = init ^ (((c / hpe) % 2) == 1);
            cnt = 8'(c / hpe);
            exp_q.push_back({a, 1'b1, 1'b0, cnt});
            if (c == abort_c) begin
                for (int k = 0; k < idle_n; k++) exp_q.push_back({a, 1'b0, 1'b0, cnt});
                return;
            end
        end
        a   = init ^ ((n % 2) == 1);
        cnt = 8'(n);
        exp_q.push_back({a, 1'b0, 1'b1, cnt});
        for (int k = 0; k < idle_n; k++) exp_q.push_back({a, 1'b0, 1'b0, cnt});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic init, input int hp, input int n);
        bus.init_level  = init;
        bus.half_period = 8'(hp);
        bus.num_toggles = 8'(n);
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
        // later parameter changes must not affect the run in progress
        bus.half_period = 8'($urandom);
        bus.num_toggles = 8'($urandom);
        bus.init_level  = 1'($urandom);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [10:0] obs;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.init_level = 1'b1;
        bus.half_period = 8'd3; bus.num_toggles = 8'd3;
        #12;
        obs = observed();
        total++;
        if (obs !== 11'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", obs, 11'd0);
        end
        rst_n = 1'b1;
        // start low (abort high, which idle must ignore) keeps everything at zero
        bus.abort = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            obs = observed();
            total++;
            if (obs !== 11'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs, 11'd0);
            end
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_basic();
        logic [10:0] obs, exp;
        int idx;
        build_run(1'b0, 2, 5, -1, 2);
        launch(1'b0, 2, 5);
        idx = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            obs = observed();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL basic idx=%0d got=%h want=%h", idx, obs, exp);
            end
            idx++;
            if (exp_q.size() > 0) step();
        end
    endtask

    task automatic test_zero();
        logic [10:0] obs, exp;
        int idx;
        build_run(1'b1, 0, 0, -1, 3);
        launch(1'b1, 0, 0);
        idx = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            obs = observed();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL zero idx=%0d got=%h want=%h", idx, obs, exp);
            end
            // idx 1 is the done cycle: a start here must be dropped
            bus.start = (idx == 1);
            idx++;
            if (exp_q.size() > 0) step();
            bus.start = 1'b0;
        end
    endtask

    task automatic test_abort();
        logic [10:0] obs, exp;
        int idx;
        // abort at the last cycle of level 4, where the 5th toggle would happen
        build_run(1'b0, 3, 10, 14, 3);
        launch(1'b0, 3, 10);
        idx = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            obs = observed();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL abort idx=%0d got=%h want=%h", idx, obs, exp);
            end
            bus.start = (idx == 3 || idx == 8);
            bus.abort = (idx == 14);
            idx++;
            if (exp_q.size() > 0) step();
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
    endtask

    task automatic test_max();
        logic [10:0] obs, exp;
        int idx;
        build_run(1'b1, 1, 255, -1, 2);
        launch(1'b1, 1, 255);
        idx = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            obs = observed();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL max idx=%0d got=%h want=%h", idx, obs, exp);
            end
            idx++;
            if (exp_q.size() > 0) step();
        end
    endtask

    task automatic test_reset_midrun();
        logic [10:0] obs, exp;
        build_run(1'b1, 4, 8, -1, 1);
        launch(1'b1, 4, 8);
        for (int i = 0; i < 10; i++) begin
            exp = exp_q.pop_front();
            obs = observed();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL midrun idx=%0d got=%h want=%h", i, obs, exp);
            end
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        obs = observed();
        total++;
        if (obs !== 11'd0) begin
            bad++;
            $display("FAIL midrun_async got=%h want=%h", obs, 11'd0);
        end
        step();
        obs = observed();
        total++;
        if (obs !== 11'd0) begin
            bad++;
            $display("FAIL midrun_held got=%h want=%h", obs, 11'd0);
        end
        #3 rst_n = 1'b1;
        step();
        // fresh run after reset
        build_run(1'b0, 2, 3, -1, 1);
        launch(1'b0, 2, 3);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            obs = observed();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL midrun_fresh left=%0d got=%h want=%h", exp_q.size(), obs, exp);
            end
            if (exp_q.size() > 0) step();
        end
    endtask

    task automatic test_random();
        logic [10:0] obs, exp;
        logic init;
        int hp, n, hpe, abort_c, idx;
        for (int r = 0; r < 12; r++) begin
            init    = 1'($urandom);
            hp      = $urandom_range(0, 5);
            n       = $urandom_range(0, 15);
            hpe     = (hp == 0) ? 1 : hp;
            abort_c = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (n + 1) * hpe - 1) : -1;
            build_run(init, hp, n, abort_c, $urandom_range(1, 4));
            launch(init, hp, n);
            idx = 0;
            while (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                obs = observed();
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL random run=%0d hp=%0d n=%0d idx=%0d got=%h want=%h",
                             r, hp, n, idx, obs, exp);
                end
                bus.abort = (idx == abort_c);
                idx++;
                if (exp_q.size() > 0) step();
                bus.abort = 1'b0;
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_zero();
        test_abort();
        test_max();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
